// File: rtl/decode_stage_if.sv
// Decode-to-execute bundle: the D/E pipeline register contents presented to execute.
// The decode stage drives it through the master modport; execute consumes it as slave.
interface decode_stage_if;
   logic [31:0] rd1_e;
   logic [31:0] rd2_e;
   logic [31:0] imm_ext_e;
   logic [3:0]  rs1_e;
   logic [3:0]  rs2_e;
   logic [3:0]  rd_e;
   logic [14:0] pc_e;
   logic        reg_write_e;
   logic        mem_write_e;
   logic        result_src_e;
   logic        alu_src_e;
   logic        branch_e;
   logic        jump_e;
   logic [1:0]  alu_control_e;

   modport master (
      output rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e,
      output reg_write_e, mem_write_e, result_src_e, alu_src_e, branch_e, jump_e,
      output alu_control_e
   );

   modport slave (
      input rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e,
      input reg_write_e, mem_write_e, result_src_e, alu_src_e, branch_e, jump_e,
      input alu_control_e
   );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, 16x32 register file, load-use stall and flush squash,
// D/E pipeline register. Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data.
module decode_stage (
   input  logic               clk,
   input  logic               reset,
   input  logic [19:0]        instr_d,
   input  logic [14:0]        pc_d,
   input  logic               reg_write_w,
   input  logic [3:0]         rd_w,
   input  logic [31:0]        result_w,
   input  logic               flush_e,
   decode_stage_if.master     de,
   output logic               stall_d,
   output logic               illegal_d
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LDR  = 4'd6;
   localparam logic [3:0] OP_STR  = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_B    = 4'd9;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [3:0]  rd;
      logic [14:0] pc;
      logic        reg_write;
      logic        mem_write;
      logic        result_src;
      logic        alu_src;
      logic        branch;
      logic        jump;
      logic [1:0]  alu_control;
   } de_t;

   logic [3:0]  op;
   logic [3:0]  rd_f;
   logic [3:0]  rs1_f;
   logic [3:0]  rs2_f;
   logic [7:0]  imm8;

   logic        reg_write_d;
   logic        mem_write_d;
   logic        result_src_d;
   logic        alu_src_d;
   logic        branch_d;
   logic        jump_d;
   logic [1:0]  alu_control_d;
   logic [31:0] imm_ext_d;
   logic        use_rs1_d;
   logic        use_rs2_d;
   logic [3:0]  rs2_sel_d;

   logic [31:0] regs_reg [16];
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;

   logic        load_use;
   logic        bubble;
   logic        squash_reg;
   de_t         de_reg;
   de_t         de_next;

   assign op    = instr_d[19:16];
   assign rd_f  = instr_d[15:12];
   assign rs1_f = instr_d[11:8];
   assign rs2_f = instr_d[7:4];
   assign imm8  = instr_d[7:0];

   always_comb begin
      reg_write_d   = 1'b0;
      mem_write_d   = 1'b0;
      result_src_d  = 1'b0;
      alu_src_d     = 1'b0;
      branch_d      = 1'b0;
      jump_d        = 1'b0;
      alu_control_d = 2'b00;
      imm_ext_d     = 32'd0;
      use_rs1_d     = 1'b0;
      use_rs2_d     = 1'b0;
      rs2_sel_d     = rs2_f;
      illegal_d     = 1'b0;
      case (op)
         OP_NOP: ;
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            reg_write_d = 1'b1;
            use_rs1_d   = 1'b1;
            use_rs2_d   = 1'b1;
            case (op)
               OP_ADD:  alu_control_d = 2'b00;
               OP_SUB:  alu_control_d = 2'b01;
               OP_AND:  alu_control_d = 2'b10;
               default: alu_control_d = 2'b11;
            endcase
         end
         OP_ADDI, OP_LDR: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 1'b1;
            result_src_d = (op == OP_LDR);
            use_rs1_d    = 1'b1;
            imm_ext_d    = {{24{imm8[7]}}, imm8};
         end
         OP_STR: begin
            // Store data register sits in the rd field and is read on the second port
            mem_write_d = 1'b1;
            alu_src_d   = 1'b1;
            use_rs1_d   = 1'b1;
            use_rs2_d   = 1'b1;
            rs2_sel_d   = rd_f;
            imm_ext_d   = {{24{imm8[7]}}, imm8};
         end
         OP_BEQ: begin
            branch_d      = 1'b1;
            alu_control_d = 2'b01;
            use_rs1_d     = 1'b1;
            use_rs2_d     = 1'b1;
            imm_ext_d     = {{24{rd_f[3]}}, rd_f, instr_d[3:0]};
         end
         OP_B: begin
            jump_d    = 1'b1;
            imm_ext_d = {{17{instr_d[14]}}, instr_d[14:0]};
         end
         default: illegal_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            regs_reg[i] <= 32'd0;
         end
      end else if (reg_write_w && (rd_w != 4'd0)) begin
         regs_reg[rd_w] <= result_w;
      end
   end

   function automatic logic [31:0] read_port(input logic [3:0] addr);
      logic [31:0] val;
      val = (addr == 4'd0) ? 32'd0 : regs_reg[addr];
`ifdef DECODE_WB_BYPASS_EN
      if (reg_write_w && (rd_w != 4'd0) && (rd_w == addr)) begin
         val = result_w;
      end
`endif
      return val;
   endfunction

   assign rd1_d = read_port(rs1_f);
   assign rd2_d = read_port(rs2_sel_d);

   // Only registers the instruction really consumes may trigger a load-use stall
   assign load_use = de_reg.result_src && de_reg.reg_write && (de_reg.rd != 4'd0) &&
                     ((use_rs1_d && (rs1_f == de_reg.rd)) ||
                      (use_rs2_d && (rs2_sel_d == de_reg.rd)));
   assign stall_d  = load_use && !squash_reg;
   assign bubble   = flush_e || squash_reg || stall_d;

   always_comb begin
      de_next             = '0;
      de_next.rd1         = rd1_d;
      de_next.rd2         = rd2_d;
      de_next.imm         = imm_ext_d;
      de_next.rs1         = rs1_f;
      de_next.rs2         = rs2_sel_d;
      de_next.pc          = pc_d;
      if (!bubble) begin
         de_next.rd          = reg_write_d ? rd_f : 4'd0;
         de_next.reg_write   = reg_write_d;
         de_next.mem_write   = mem_write_d;
         de_next.result_src  = result_src_d;
         de_next.alu_src     = alu_src_d;
         de_next.branch      = branch_d;
         de_next.jump        = jump_d;
         de_next.alu_control = alu_control_d;
      end
   end

   // squash_reg marks the second bubble after a flush; a new flush simply re-arms it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_reg     <= '0;
         squash_reg <= 1'b0;
      end else begin
         de_reg     <= de_next;
         squash_reg <= flush_e;
      end
   end

   assign de.rd1_e         = de_reg.rd1;
   assign de.rd2_e         = de_reg.rd2;
   assign de.imm_ext_e     = de_reg.imm;
   assign de.rs1_e         = de_reg.rs1;
   assign de.rs2_e         = de_reg.rs2;
   assign de.rd_e          = de_reg.rd;
   assign de.pc_e          = de_reg.pc;
   assign de.reg_write_e   = de_reg.reg_write;
   assign de.mem_write_e   = de_reg.mem_write;
   assign de.result_src_e  = de_reg.result_src;
   assign de.alu_src_e     = de_reg.alu_src;
   assign de.branch_e      = de_reg.branch;
   assign de.jump_e        = de_reg.jump;
   assign de.alu_control_e = de_reg.alu_control;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts each D/E load, a monitor
// compares after every rising edge; stall_d/illegal_d are checked combinationally.
module tb_decode_stage;

   typedef struct packed {
      logic        bubble;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [3:0]  rd;
      logic [14:0] pc;
      logic        rw;
      logic        mw;
      logic        rsrc;
      logic        asrc;
      logic        br;
      logic        jp;
      logic [1:0]  alu;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [19:0] instr_d = '0;
   logic [14:0] pc_d = '0;
   logic        reg_write_w = 1'b0;
   logic [3:0]  rd_w = '0;
   logic [31:0] result_w = '0;
   logic        flush_e = 1'b0;
   logic        stall_d;
   logic        illegal_d;

   decode_stage_if de();

   decode_stage dut (
      .clk         (clk),
      .reset       (reset),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .reg_write_w (reg_write_w),
      .rd_w        (rd_w),
      .result_w    (result_w),
      .flush_e     (flush_e),
      .de          (de),
      .stall_d     (stall_d),
      .illegal_d   (illegal_d)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   int          checks = 0;
   int          passes = 0;
   int          txn = 0;
   logic [31:0] mregs [16];
   int          squash_left = 0;
   exp_t        last_e = '0;
   logic        last_stall = 1'b0;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endfunction

   function automatic logic [11:0] dut_ctrl();
      return {de.reg_write_e, de.mem_write_e, de.result_src_e, de.alu_src_e,
              de.branch_e, de.jump_e, de.alu_control_e, de.rd_e};
   endfunction

   // Registers an instruction genuinely reads, by opcode meaning
   function automatic logic uses_reg(input logic [19:0] ins, input logic [3:0] r);
      int op = int'(ins[19:16]);
      if (op >= 1 && op <= 4) return (ins[11:8] == r) || (ins[7:4] == r);
      if (op == 5 || op == 6) return (ins[11:8] == r);
      if (op == 7) return (ins[11:8] == r) || (ins[15:12] == r);
      if (op == 8) return (ins[11:8] == r) || (ins[7:4] == r);
      return 1'b0;
   endfunction

   function automatic logic [31:0] rdval(input logic [3:0] r, input logic we,
                                         input logic [3:0] wrd, input logic [31:0] wres);
      if (r == 4'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (we && wrd == r) return wres;
`endif
      return mregs[r];
   endfunction

   function automatic exp_t model_decode(input logic [19:0] ins, input logic [14:0] pc,
                                         input logic we, input logic [3:0] wrd,
                                         input logic [31:0] wres);
      exp_t e = '0;
      int   op = int'(ins[19:16]);
      int   s8 = int'(ins[7:0]);
      int   off;
      if (s8 >= 128) s8 -= 256;
      e.rs1 = ins[11:8];
      e.rs2 = (op == 7) ? ins[15:12] : ins[7:4];
      e.pc  = pc;
      e.rd1 = rdval(e.rs1, we, wrd, wres);
      e.rd2 = rdval(e.rs2, we, wrd, wres);
      case (op)
         1, 2, 3, 4: begin e.rw = 1; e.alu = 2'(op - 1); e.rd = ins[15:12]; end
         5: begin e.rw = 1; e.asrc = 1; e.imm = 32'(s8); e.rd = ins[15:12]; end
         6: begin e.rw = 1; e.asrc = 1; e.rsrc = 1; e.imm = 32'(s8); e.rd = ins[15:12]; end
         7: begin e.mw = 1; e.asrc = 1; e.imm = 32'(s8); end
         8: begin
            off = int'(ins[15:12]) * 16 + int'(ins[3:0]);
            if (off >= 128) off -= 256;
            e.br = 1; e.alu = 2'd1; e.imm = 32'(off);
         end
         9: begin
            off = int'(ins[14:0]);
            if (off >= 16384) off -= 32768;
            e.jp = 1; e.imm = 32'(off);
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic step(input logic [19:0] ins, input logic fl = 1'b0, input logic we = 1'b0,
                       input logic [3:0] wrd = 4'd0, input logic [31:0] wres = 32'd0);
      exp_t e;
      logic exp_stall;
      logic [14:0] pc;
      @(negedge clk);
      pc = 15'($urandom);
      instr_d = ins; pc_d = pc; flush_e = fl;
      reg_write_w = we; rd_w = wrd; result_w = wres;
      #1;
      exp_stall = last_e.rsrc && last_e.rw && (last_e.rd != 0) &&
                  uses_reg(ins, last_e.rd) && (squash_left == 0);
      chk("stall_d", stall_d, exp_stall);
      chk("illegal_d", illegal_d, ins[19:16] >= 4'd10);
      e = model_decode(ins, pc, we, wrd, wres);
      if (fl || squash_left > 0 || exp_stall) begin
         e.rw = 0; e.mw = 0; e.rsrc = 0; e.asrc = 0; e.br = 0; e.jp = 0; e.alu = 0; e.rd = 0;
         e.bubble = 1;
      end
      squash_left = fl ? 1 : (squash_left > 0 ? squash_left - 1 : 0);
      if (we && wrd != 0) mregs[wrd] = wres;
      last_e = e;
      last_stall = exp_stall;
      q.push_back(e);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_ctrl"}, {stall_d, dut_ctrl(), de.rs1_e, de.rs2_e, de.pc_e}, '0);
      chk({name, "_data"}, {de.rd1_e, de.rd2_e, de.imm_ext_e}, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all_zero("reset_async");
      @(posedge clk);
      #1;
      check_all_zero("reset_held");
      for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
      squash_left = 0;
      last_e = '0;
      last_stall = 1'b0;
      reset = 1'b1;
   endtask

   function automatic logic [19:0] mk(input int op, input int rd, input int rs1,
                                      input int rs2, input int lo);
      return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], lo[3:0]};
   endfunction

   // Monitor: compare each D/E load against the oldest prediction
   initial begin
      exp_t m;
      forever begin
         @(posedge clk);
         #1;
         if (reset && q.size() > 0) begin
            m = q.pop_front();
            chk("de_ctrl", dut_ctrl(), {m.rw, m.mw, m.rsrc, m.asrc, m.br, m.jp, m.alu, m.rd});
            if (!m.bubble)
               chk("de_data", {de.rd1_e, de.rd2_e, de.imm_ext_e, de.rs1_e, de.rs2_e, de.pc_e},
                   {m.rd1, m.rd2, m.imm, m.rs1, m.rs2, m.pc});
            $display("txn %0d bubble=%0b rd_e=%0d rw=%0b mw=%0b imm=%h", txn, m.bubble,
                     de.rd_e, de.reg_write_e, de.mem_write_e, de.imm_ext_e);
            txn++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [19:0] ins;
      for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
      #6;
      check_all_zero("reset_initial");
      reset = 1'b1;

      // Writeback then R-type read of the written register
      step(mk(0, 0, 0, 0, 0), 0, 1, 3, 32'h12345678);
      step(mk(1, 4, 3, 3, 0));
      #5;
      chk("add_operands", {de.rd1_e, de.rd2_e}, {32'h12345678, 32'h12345678});
      chk("add_ctrl", {de.alu_control_e, de.rd_e}, {2'b00, 4'd4});

      // ADDI with negative immediate
      step({4'd5, 4'd2, 4'd1, 8'hF0});
      #5;
      chk("addi_imm", {de.imm_ext_e, de.alu_src_e, de.reg_write_e}, {32'hFFFFFFF0, 1'b1, 1'b1});

      // Load-use: one stall cycle, bubble, then the ADD issues
      step({4'd6, 4'd5, 4'd1, 8'h04});
      step(mk(1, 6, 5, 1, 0));
      chk("load_use_stall", stall_d, 1'b1);
      #5;
      chk("load_use_bubble", {de.reg_write_e, de.rd_e}, {1'b0, 4'd0});
      step(mk(1, 6, 5, 1, 0));
      chk("load_use_release", stall_d, 1'b0);
      #5;
      chk("load_use_issue", {de.reg_write_e, de.rd_e}, {1'b1, 4'd6});

      // Flush: two bubbles then the third instruction passes
      step(mk(1, 8, 1, 1, 0), 1);
      #5;
      chk("flush_bubble1", {de.reg_write_e, de.mem_write_e}, 2'b00);
      step(mk(7, 2, 1, 0, 0));
      #5;
      chk("flush_bubble2", {de.reg_write_e, de.mem_write_e}, 2'b00);
      step(mk(1, 9, 1, 1, 0));
      #5;
      chk("flush_pass", {de.reg_write_e, de.rd_e}, {1'b1, 4'd9});

      // Flush re-asserted during a squash extends it
      step(mk(1, 8, 1, 1, 0), 1);
      step(mk(1, 8, 1, 1, 0), 1);
      step(mk(1, 8, 1, 1, 0));
      #5;
      chk("reflush_bubble3", de.reg_write_e, 1'b0);
      step(mk(1, 10, 1, 1, 0));
      #5;
      chk("reflush_pass", {de.reg_write_e, de.rd_e}, {1'b1, 4'd10});

      // Same-cycle writeback versus read
      step(mk(0, 0, 0, 0, 0), 0, 1, 7, 32'h11);
      step(mk(1, 8, 7, 0, 0), 0, 1, 7, 32'hA5);
      #5;
`ifdef DECODE_WB_BYPASS_EN
      chk("wb_bypass", de.rd1_e, 32'hA5);
`else
      chk("wb_no_bypass", de.rd1_e, 32'h11);
`endif

      // Illegal opcode decodes as NOP controls
      step({4'hC, 16'hFFFF});
      chk("illegal_flag", illegal_d, 1'b1);
      #5;
      chk("illegal_ctrl", dut_ctrl(), 12'd0);

      // Branch and jump offsets
      step({4'd8, 4'hF, 4'd1, 4'd2, 4'h8});
      #5;
      chk("beq_imm", {de.imm_ext_e, de.branch_e}, {32'hFFFFFFF8, 1'b1});
      step({4'd9, 1'b0, 15'h4000});
      #5;
      chk("b_imm", {de.imm_ext_e, de.jump_e}, {32'hFFFFC000, 1'b1});

      // R0 ignores writes and reads zero
      step(mk(0, 0, 0, 0, 0), 0, 1, 0, 32'hDEAD);
      step(mk(1, 1, 0, 0, 0));
      #5;
      chk("r0_zero", de.rd1_e, 32'd0);

      // Randomized stream with a mid-stream reset
      for (int i = 0; i < 300; i++) begin
         if (i == 150) do_reset();
         if (!last_stall) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               ins[19:16] = 4'($urandom_range(0, 9));
               ins[15:12] = 4'($urandom_range(0, 3));
               ins[11:8]  = 4'($urandom_range(0, 3));
               ins[7:4]   = 4'($urandom_range(0, 3));
            end
         end
         step(ins, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drain", 128'(q.size()), 128'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
